// File: rtl/branch_resolve_if.sv
// Bundle of the resolve-stage request/response signals and the fetch-side
// BHT lookup port. The master drives instructions and lookups; the slave
// is the branch resolve unit.
interface branch_resolve_if #(
    parameter int XLEN            = 32,
    parameter int OFFSET_SIZE     = 13,
    parameter int JAL_OFFSET_SIZE = 21,
    parameter int OPERATION_SIZE  = 3
);
    logic                       in_valid;
    logic [OPERATION_SIZE-1:0]  in_op;
    logic [XLEN-1:0]            in_pc;
    logic [XLEN-1:0]            in_rs1;
    logic [XLEN-1:0]            in_rs2;
    logic [OFFSET_SIZE-1:0]     in_offset;
    logic [JAL_OFFSET_SIZE-1:0] in_jal_offset;
    logic                       in_pred_taken;
    logic                       flush;
    logic [XLEN-1:0]            pred_pc;
    logic                       pred_taken;
    logic                       out_valid;
    logic                       out_taken;
    logic [XLEN-1:0]            out_target;
    logic [XLEN-1:0]            out_link;
    logic                       out_mispredict;
    logic [XLEN-1:0]            out_redirect_pc;

    modport master (
        output in_valid, in_op, in_pc, in_rs1, in_rs2, in_offset,
               in_jal_offset, in_pred_taken, flush, pred_pc,
        input  pred_taken, out_valid, out_taken, out_target, out_link,
               out_mispredict, out_redirect_pc
    );

    modport slave (
        input  in_valid, in_op, in_pc, in_rs1, in_rs2, in_offset,
               in_jal_offset, in_pred_taken, flush, pred_pc,
        output pred_taken, out_valid, out_taken, out_target, out_link,
               out_mispredict, out_redirect_pc
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Registered jump/branch resolution stage. Resolves JAL/JALR and the six
// conditional branches one cycle after capture, flags mispredicts against
// the fetch prediction, and owns a 2-bit saturating-counter BHT that fetch
// reads combinationally and that is trained when a branch is captured.
module branch_resolve_unit #(
    parameter int XLEN            = 32,
    parameter int OFFSET_SIZE     = 13,
    parameter int JAL_OFFSET_SIZE = 21,
    parameter int OPERATION_SIZE  = 3,
    parameter int BHT_INDEX_BITS  = 6
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bru
);
    localparam int BHT_ENTRIES = 1 << BHT_INDEX_BITS;

    localparam logic [OPERATION_SIZE-1:0] OP_JAL  = OPERATION_SIZE'(3'd0);
    localparam logic [OPERATION_SIZE-1:0] OP_JALR = OPERATION_SIZE'(3'd1);
    localparam logic [OPERATION_SIZE-1:0] OP_BEQ  = OPERATION_SIZE'(3'd2);
    localparam logic [OPERATION_SIZE-1:0] OP_BNE  = OPERATION_SIZE'(3'd3);
    localparam logic [OPERATION_SIZE-1:0] OP_BLT  = OPERATION_SIZE'(3'd4);
    localparam logic [OPERATION_SIZE-1:0] OP_BGE  = OPERATION_SIZE'(3'd5);
    localparam logic [OPERATION_SIZE-1:0] OP_BLTU = OPERATION_SIZE'(3'd6);
    localparam logic [OPERATION_SIZE-1:0] OP_BGEU = OPERATION_SIZE'(3'd7);

    localparam logic [XLEN-1:0] PC_STEP        = XLEN'(32'd4);
    localparam logic [XLEN-1:0] LSB_CLEAR_MASK = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [1:0]      CTR_RESET      = 2'b01;
    localparam logic [1:0]      CTR_MAX        = 2'b11;
    localparam logic [1:0]      CTR_MIN        = 2'b00;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == CTR_MAX) ? ctr : ctr + 2'd1;
        end else begin
            nxt = (ctr == CTR_MIN) ? ctr : ctr - 2'd1;
        end
        return nxt;
    endfunction

    logic [1:0]                bht_r [BHT_ENTRIES];
    logic                      out_valid_r;
    logic                      out_taken_r;
    logic [XLEN-1:0]           out_target_r;
    logic [XLEN-1:0]           out_link_r;
    logic                      out_mispredict_r;
    logic [XLEN-1:0]           out_redirect_pc_r;

    logic [XLEN-1:0]           off_sext_s;
    logic [XLEN-1:0]           jal_off_sext_s;
    logic [XLEN-1:0]           link_s;
    logic [XLEN-1:0]           jalr_sum_s;
    logic [XLEN-1:0]           target_s;
    logic [XLEN-1:0]           redirect_s;
    logic                      taken_s;
    logic                      is_branch_s;
    logic                      mispredict_s;
    logic                      capture_s;
    logic                      eq_s;
    logic                      lt_s;
    logic                      ltu_s;
    logic [BHT_INDEX_BITS-1:0] upd_idx_s;
    logic [BHT_INDEX_BITS-1:0] lookup_idx_s;
    logic                      unused_pred_pc_bits_s;

    assign off_sext_s     = {{(XLEN-OFFSET_SIZE){bru.in_offset[OFFSET_SIZE-1]}}, bru.in_offset};
    assign jal_off_sext_s = {{(XLEN-JAL_OFFSET_SIZE){bru.in_jal_offset[JAL_OFFSET_SIZE-1]}},
                             bru.in_jal_offset};
    assign link_s         = bru.in_pc + PC_STEP;
    assign jalr_sum_s     = bru.in_rs1 + off_sext_s;
    assign eq_s           = (bru.in_rs1 == bru.in_rs2);
    assign lt_s           = ($signed(bru.in_rs1) < $signed(bru.in_rs2));
    assign ltu_s          = (bru.in_rs1 < bru.in_rs2);
    assign capture_s      = bru.in_valid && !bru.flush;
    assign is_branch_s    = (bru.in_op >= OP_BEQ);
    assign upd_idx_s      = bru.in_pc[BHT_INDEX_BITS+1:2];
    assign lookup_idx_s   = bru.pred_pc[BHT_INDEX_BITS+1:2];

    // Only the index bits of the fetch PC select a BHT entry.
    assign unused_pred_pc_bits_s = ^{bru.pred_pc[XLEN-1:BHT_INDEX_BITS+2], bru.pred_pc[1:0]};

    // Fetch lookup reads the pre-edge counter, giving read-before-write.
    assign bru.pred_taken = bht_r[lookup_idx_s][1];

    // Resolve outcome and target for the instruction on the inputs.
    always_comb begin
        taken_s  = 1'b0;
        target_s = bru.in_pc + off_sext_s;
        case (bru.in_op)
            OP_JAL: begin
                taken_s  = 1'b1;
                target_s = bru.in_pc + jal_off_sext_s;
            end
            OP_JALR: begin
                taken_s  = 1'b1;
                target_s = jalr_sum_s & LSB_CLEAR_MASK;
            end
            OP_BEQ:  taken_s = eq_s;
            OP_BNE:  taken_s = !eq_s;
            OP_BLT:  taken_s = lt_s;
            OP_BGE:  taken_s = !lt_s;
            OP_BLTU: taken_s = ltu_s;
            OP_BGEU: taken_s = !ltu_s;
            default: begin
                taken_s  = 1'b0;
                target_s = bru.in_pc + off_sext_s;
            end
        endcase
    end

    // Mispredict detection: jumps always redirect since no target buffer exists.
    always_comb begin
        mispredict_s = 1'b1;
        if (is_branch_s) begin
            mispredict_s = taken_s ^ bru.in_pred_taken;
        end else begin
            mispredict_s = 1'b1;
        end
        redirect_s = taken_s ? target_s : link_s;
    end

    // Result register: one-cycle valid pulse, data held when nothing is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r       <= 1'b0;
            out_taken_r       <= 1'b0;
            out_target_r      <= '0;
            out_link_r        <= '0;
            out_mispredict_r  <= 1'b0;
            out_redirect_pc_r <= '0;
        end else if (capture_s) begin
            out_valid_r       <= 1'b1;
            out_taken_r       <= taken_s;
            out_target_r      <= target_s;
            out_link_r        <= link_s;
            out_mispredict_r  <= mispredict_s;
            out_redirect_pc_r <= redirect_s;
        end else begin
            out_valid_r       <= 1'b0;
        end
    end

    // BHT training: captured conditional branches nudge their counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_RESET;
            end
        end else if (capture_s && is_branch_s) begin
            bht_r[upd_idx_s] <= ctr_next(bht_r[upd_idx_s], taken_s);
        end
    end

    assign bru.out_valid       = out_valid_r;
    assign bru.out_taken       = out_taken_r;
    assign bru.out_target      = out_target_r;
    assign bru.out_link        = out_link_r;
    assign bru.out_mispredict  = out_mispredict_r;
    assign bru.out_redirect_pc = out_redirect_pc_r;
endmodule
